// File: rtl/uart_prog_loader_if.sv
// Byte-receiver and instruction-memory write bundle for the program loader.
// The master side is the loader: it consumes received bytes and drives imem writes.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 6
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: frame = 16-bit LE word count + count*4 LE data bytes, written to imem from 0.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_prog_loader #(
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    uart_prog_loader_if.master   bus,
    output logic                 core_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          words_loaded
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        CHK    = 3'd4,
`endif
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              crst_q, crst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [15:0]       wl_q, wl_d;
    logic              timeout_hit_s;
    logic [16:0]       len_full_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= 16'd0;
            bidx_q  <= 2'd0;
            wbuf_q  <= 24'd0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            crst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wl_q    <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bidx_q  <= bidx_d;
            wbuf_q  <= wbuf_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            crst_q  <= crst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            wl_q    <= wl_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Next-state and next-output logic; the write strobe defaults low so it is a single-cycle pulse
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        bidx_d        = bidx_q;
        wbuf_d        = wbuf_q;
        cnt_d         = cnt_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        crst_d        = crst_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        wl_d          = wl_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d         = chk_q;
`endif
        timeout_hit_s = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        len_full_s    = {1'b0, bus.rx_data, len_q[7:0]};

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LEN_LO;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    wl_d    = 16'd0;
                    crst_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bidx_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = 8'd0;
`endif
                end else begin
                    crst_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            LEN_LO: begin
                if (!enable) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    crst_d  = 1'b1;
                end else if (bus.rx_valid) begin
                    len_d[7:0] = bus.rx_data;
                    cnt_d      = '0;
                    state_d    = LEN_HI;
                end else begin
                    cnt_d      = '0;
                end
            end
            LEN_HI: begin
                if (!enable) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    crst_d  = 1'b1;
                end else if (bus.rx_valid) begin
                    len_d[15:8] = bus.rx_data;
                    cnt_d       = '0;
                    if (len_full_s > 17'(DEPTH)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else if (len_full_s == 17'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        crst_d  = 1'b1;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else if (timeout_hit_s) begin
                    state_d = ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + TO_W'(1);
                end
            end
            DATA: begin
                if (!enable) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    crst_d  = 1'b1;
                end else if (bus.rx_valid) begin
                    cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_fold(chk_q, bus.rx_data);
`endif
                    case (bidx_q)
                        2'd0: wbuf_d[7:0]   = bus.rx_data;
                        2'd1: wbuf_d[15:8]  = bus.rx_data;
                        2'd2: wbuf_d[23:16] = bus.rx_data;
                        2'd3: begin
                            we_d    = 1'b1;
                            addr_d  = wl_q[ADDR_W-1:0];
                            wdata_d = {bus.rx_data, wbuf_q};
                            wl_d    = wl_q + 16'd1;
                            if ((wl_q + 16'd1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                                state_d = CHK;
`else
                                state_d = DONE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                crst_d  = 1'b1;
`endif
                            end else begin
                                state_d = DATA;
                            end
                        end
                        default: wbuf_d = wbuf_q;
                    endcase
                    bidx_d = bidx_q + 2'd1;
                end else if (timeout_hit_s) begin
                    state_d = ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + TO_W'(1);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (!enable) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    crst_d  = 1'b1;
                end else if (bus.rx_valid) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    if (bus.rx_data == chk_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        crst_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end else if (timeout_hit_s) begin
                    state_d = ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + TO_W'(1);
                end
            end
`endif
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                    crst_d  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            ERR: begin
                if (!enable) begin
                    state_d = IDLE;
                    crst_d  = 1'b1;
                end else begin
                    state_d = ERR;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign core_rst_n     = crst_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = wl_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized self-checking bench for uart_prog_loader against a frame-level reference model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_uart_prog_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int TO     = 60;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bus          (bus.master),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] got_addr[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            got_data.push_back(bus.imem_wdata);
            got_addr.push_back(bus.imem_addr);
        end
    end

    // Reference model: expected words, which byte triggers a write, and the final verdict
    bit          exp_flag[$];
    logic [31:0] exp_w[$];
    bit          exp_done, exp_err;
    int          exp_words;

    task automatic model_frame(input bq_t b);
        int len;
        exp_flag.delete();
        exp_w.delete();
        for (int i = 0; i < b.size(); i++) exp_flag.push_back(1'b0);
        len       = int'({b[1], b[0]});
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_words = 0;
        if (len > DEPTH) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_w.push_back({b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]});
                exp_flag[2+4*i+3] = 1'b1;
            end
            exp_words = len;
`ifdef LOADER_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 2; i < 2 + 4 * len; i++) x = x ^ b[i];
                if (b[2+4*len] == x) exp_done = 1'b1;
                else exp_err = 1'b1;
            end
`else
            exp_done = 1'b1;
`endif
        end
    endtask

    // Present one byte for one cycle and check the write strobe right after its accepting edge
    task automatic send_byte(input logic [7:0] b, input bit exp_we, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        total++;
        if (bus.imem_we !== exp_we) begin
            bad++;
            $display("FAIL we_after_byte: byte=%02h imem_we=%b required=%b", b, bus.imem_we, exp_we);
        end
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic start_frame();
        got_data.delete();
        got_addr.delete();
        enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, error, core_rst_n} !== 4'b1000) begin
            bad++;
            $display("FAIL frame_start: busy/done/error/core_rst_n=%b required=1000", {busy, done, error, core_rst_n});
        end
    endtask

    task automatic run_frame(input string name, input bq_t b, input int mingap, input int maxgap);
        model_frame(b);
        start_frame();
        for (int i = 0; i < b.size(); i++)
            send_byte(b[i], exp_flag[i], int'($urandom_range(maxgap, mingap)));
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (got_data.size() !== exp_w.size()) begin
            bad++;
            $display("FAIL %s write_count: got=%0d required=%0d", name, got_data.size(), exp_w.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++) begin
                total++;
                if (got_data[i] !== exp_w[i] || got_addr[i] !== ADDR_W'(i)) begin
                    bad++;
                    $display("FAIL %s write[%0d]: addr=%0d data=%08h required addr=%0d data=%08h",
                             name, i, got_addr[i], got_data[i], i, exp_w[i]);
                end
            end
        end
        total++;
        if ({done, error, busy, core_rst_n} !== {exp_done, exp_err, 1'b0, exp_done}) begin
            bad++;
            $display("FAIL %s status: done/error/busy/core_rst_n=%b required=%b", name,
                     {done, error, busy, core_rst_n}, {exp_done, exp_err, 1'b0, exp_done});
        end
        total++;
        if (words_loaded !== 16'(exp_words)) begin
            bad++;
            $display("FAIL %s words_loaded: got=%0d required=%0d", name, words_loaded, exp_words);
        end
    endtask

    task automatic end_frame(input string name);
        enable = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({core_rst_n, busy, done, error} !== {1'b1, 1'b0, exp_done, exp_err}) begin
            bad++;
            $display("FAIL %s release: core_rst_n/busy/done/error=%b required=%b", name,
                     {core_rst_n, busy, done, error}, {1'b1, 1'b0, exp_done, exp_err});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst_n, busy, done, error, words_loaded} !== '0) begin
            bad++;
            $display("FAIL reset_values: we=%b addr=%0d wdata=%08h crst=%b busy=%b done=%b err=%b wl=%0d required all 0",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst_n, busy, done, error, words_loaded);
        end
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if ({core_rst_n, busy} !== 2'b10) begin
            bad++;
            $display("FAIL idle_after_reset: core_rst_n/busy=%b required=10", {core_rst_n, busy});
        end
    endtask

    task automatic test_load();
        bq_t f;
        f = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'hB0);
`endif
        run_frame("load", f, 0, 0);
        total++;
        if (got_data.size() != 2 || got_data[0] !== 32'h00100513 || got_data[1] !== 32'h00200593) begin
            bad++;
            $display("FAIL load_words: count=%0d required 2 words 00100513,00200593", got_data.size());
        end
        end_frame("load");
    endtask

    task automatic test_oversize();
        bq_t f;
        f = {8'h41, 8'h00};
        run_frame("oversize", f, 0, 0);
        end_frame("oversize");
        f = {8'h41, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_frame("oversize_trailing", f, 0, 2);
        end_frame("oversize_trailing");
    endtask

    task automatic test_timeout();
        bq_t f;
        start_frame();
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h13, 1'b0, 0);
        repeat (TO - 3) begin @(posedge clk); #1; end
        total++;
        if ({error, busy} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_early: error/busy=%b required=01", {error, busy});
        end
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if ({error, done, core_rst_n, words_loaded} !== {3'b100, 16'd0} || got_data.size() != 0) begin
            bad++;
            $display("FAIL timeout_expired: error/done/crst=%b wl=%0d writes=%0d required 100, 0, 0",
                     {error, done, core_rst_n}, words_loaded, got_data.size());
        end
        exp_done = 1'b0;
        exp_err  = 1'b1;
        end_frame("timeout");
        f = {8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
        run_frame("slow_gaps", f, TO - 4, TO - 3);
        end_frame("slow_gaps");
    endtask

    task automatic test_abort();
        start_frame();
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h13, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'h10, 1'b0, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h93, 1'b0, 0);
        enable = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, done, error, core_rst_n} !== 4'b0001 || words_loaded !== 16'd1) begin
            bad++;
            $display("FAIL abort_state: busy/done/error/crst=%b wl=%0d required 0001, 1",
                     {busy, done, error, core_rst_n}, words_loaded);
        end
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'h20, 1'b0, 2);
        total++;
        if (got_data.size() != 1 || got_data[0] !== 32'h00100513) begin
            bad++;
            $display("FAIL abort_writes: count=%0d required 1 write of 00100513", got_data.size());
        end
    endtask

    task automatic test_empty();
        bq_t f;
        f = {8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h00);
`endif
        run_frame("empty", f, 0, 1);
        end_frame("empty");
    endtask

    task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
        bq_t f;
        f = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};
        run_frame("checksum_bad", f, 0, 0);
        total++;
        if ({error, core_rst_n} !== 2'b10) begin
            bad++;
            $display("FAIL checksum_bad_fixed: error/core_rst_n=%b required=10", {error, core_rst_n});
        end
        end_frame("checksum_bad");
        f[10] = 8'hB0;
        run_frame("checksum_good", f, 0, 0);
        end_frame("checksum_good");
`endif
    endtask

    task automatic test_random();
        bq_t f;
        int  len;
        for (int n = 0; n < 12; n++) begin
            if (n == 0) len = DEPTH;
            else if (n == 1) len = DEPTH + 1;
            else len = int'($urandom_range(8, 1));
            f = {};
            f.push_back(8'(len));
            f.push_back(8'(len >> 8));
            if (len <= DEPTH) begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 0; i < 4 * len; i++) begin
                    f.push_back(8'($urandom));
                    x = x ^ f[f.size()-1];
                end
`ifdef LOADER_CHECKSUM_EN
                if ($urandom_range(3, 0) == 0) f.push_back(x ^ 8'(($urandom_range(255, 1))));
                else f.push_back(x);
`endif
            end
            run_frame("random", f, 0, 3);
            end_frame("random");
        end
    endtask

    task automatic test_mid_reset();
        start_frame();
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h13, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'h10, 1'b0, 0);
        rst_n = 1'b0;
        send_byte(8'h00, 1'b0, 0);
        total++;
        if ({core_rst_n, busy, done, error, words_loaded} !== '0 || got_data.size() != 0) begin
            bad++;
            $display("FAIL mid_reset: crst/busy/done/err=%b wl=%0d writes=%0d required all 0",
                     {core_rst_n, busy, done, error}, words_loaded, got_data.size());
        end
        rst_n  = 1'b1;
        enable = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_load();
        test_oversize();
        test_timeout();
        test_abort();
        test_empty();
        test_checksum();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
